mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Multi-cycle data-memory access sequencer for the M stage of the pipelined MIPS core.
- Accepts one load or store per instruction and stalls the pipeline while the access is in flight.
- Drives a request/grant/rvalid memory bus with word-aligned address, byte enables and lane-replicated write data.
- Returns sign-extended load data and flags misaligned accesses without touching the bus.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in REQ+WAIT before abort. Used only with MEMCTL_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- m_valid  in  1  M-stage instruction valid; M inputs held stable while stall=1
- MemOp  in  3  access type: 0 NONE, 1 LW, 2 LH, 3 LB, 4 SW, 5 SH, 6 SB, 7 treated as NONE
- addr  in  32  byte address
- wdata  in  32  store data, right-aligned
- stall  out  1  freeze pipeline (combinational)
- done  out  1  one-cycle completion pulse
- rdata  out  32  extended load result
- exc_adel  out  1  misaligned load (combinational)
- exc_ades  out  1  misaligned store (combinational)
- bus_req  out  1  bus request
- bus_we  out  1  1 = write
- bus_addr  out  32  {addr[31:2],2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated write data
- bus_gnt  in  1  request accepted
- bus_rvalid  in  1  read data valid
- bus_rdata  in  32  read data
- bus_err  out  1  timeout abort pulse

Behaviour:
- Reset, asynchronous: state←IDLE. bus_req, bus_we, bus_addr, bus_be, bus_wdata, rdata, done and bus_err←0. stall forced 0 while reset is high.
- Misaligned access: LW/SW with addr[1:0]≠0; LH/SH with addr[0]≠0.
  - In IDLE with m_valid, a misaligned load gives exc_adel=1 and a misaligned store gives exc_ades=1.
  - No bus access and stall=0.
  - Exception outputs are 0 in every other state.
- IDLE:
  - Aligned, valid, non-NONE op: stall=1 in the same cycle; latch op, addr and wdata; next state REQ.
  - Otherwise stay in IDLE with stall=0.
- REQ:
  - bus_req=1; bus fields driven from latched values and held stable until the grant.
  - stall=1.
  - On bus_gnt: a store goes to DONE, a load goes to WAIT.
  - bus_req drops in the cycle after the grant.
  - bus_rvalid is ignored in REQ; the memory returns rvalid no earlier than one cycle after gnt.
- WAIT:
  - stall=1.
  - On bus_rvalid: rdata←extend(bus_rdata); next state DONE.
- DONE:
  - stall=0 and done=1 for exactly one cycle; the pipeline advances on this edge.
  - Next state IDLE. M inputs are not sampled in DONE, so back-to-back accesses take 1 idle-decision cycle each.
- Byte enables and write lanes:
  - SW: bus_be=1111, bus_wdata=wdata.
  - SH: bus_be = addr[1] ? 1100 : 0011; bus_wdata={2{wdata[15:0]}}.
  - SB: bus_be=0001<<addr[1:0]; bus_wdata={4{wdata[7:0]}}.
  - Loads: bus_be=1111, bus_we=0.
- Load extension:
  - LW: rdata = word.
  - LH: half selected by addr[1], sign-extended to 32 bits.
  - LB: byte selected by addr[1:0], sign-extended.
  - rdata holds its value until the next load completes.
- Reset mid-access: the bus request is abandoned immediately and any later bus_rvalid is ignored because the state is IDLE.
- Minimum latency, load with gnt in the first REQ cycle and rvalid one cycle later: IDLE→REQ→WAIT→DONE, 3 stall cycles. Store: 2 stall cycles.

Optional Feature:
- MEMCTL_TIMEOUT_EN defined:
  - An 8+ bit counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When the count reaches TIMEOUT_CYCLES: go to DONE with done=1 and bus_err=1 for one cycle; rdata unchanged; bus_req dropped.
- MEMCTL_TIMEOUT_EN undefined: no counter; bus_err is tied to 0; the controller waits indefinitely.

Test Plan:
- LW addr=0x1000; gnt in the first REQ cycle; rvalid with 0xDEADBEEF 2 cycles later → bus_addr=0x1000, bus_be=1111, stall high 4 cycles, done pulse, rdata=0xDEADBEEF.
- LB addr=0x2003; bus_rdata=0x80FFFFFF → rdata=0xFFFFFF80. LH addr=0x2002; bus_rdata=0x7FFF0000 → rdata=0x00007FFF.
- SB addr=0x3001, wdata=0x000000AB; gnt delayed 3 cycles → bus_req held 4 cycles, bus_be=0010, bus_wdata=0xABABABAB, bus_we=1, done after the grant.
- LW addr=0x1002 → exc_adel=1, stall=0, bus_req never asserted. SH addr=0x1001 → exc_ades=1.
- Reset asserted in WAIT, then rvalid=1 → bus_req=0, state IDLE, done never pulses, rdata=0.
- MEMCTL_TIMEOUT_EN with TIMEOUT_CYCLES=8; LW with gnt but no rvalid → bus_err and done pulse together 8 cycles after entering REQ; rdata unchanged.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// M-stage / data-bus signal bundle for mem_access_ctrl.
// master: the access controller. slave: pipeline plus memory side.
interface mem_access_ctrl_if;
    // M-stage request
    logic        m_valid;
    logic [2:0]  MemOp;
    logic [31:0] addr;
    logic [31:0] wdata;
    // M-stage response
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        exc_adel;
    logic        exc_ades;
    // Memory bus
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_err;

    modport master (
        input  m_valid, MemOp, addr, wdata, bus_gnt, bus_rvalid, bus_rdata,
        output stall, done, rdata, exc_adel, exc_ades,
               bus_req, bus_we, bus_addr, bus_be, bus_wdata, bus_err
    );

    modport slave (
        output m_valid, MemOp, addr, wdata, bus_gnt, bus_rvalid, bus_rdata,
        input  stall, done, rdata, exc_adel, exc_ades,
               bus_req, bus_we, bus_addr, bus_be, bus_wdata, bus_err
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer for the M stage: one load/store per
// instruction over a req/gnt/rvalid bus, stalling the pipeline meanwhile.
// Optional build macro MEMCTL_TIMEOUT_EN adds an abort after
// TIMEOUT_CYCLES cycles in REQ+WAIT (bus_err pulse); without it the
// controller waits indefinitely and bus_err is tied low.
module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    mem_access_ctrl_if.master mif
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] OP_LW = 3'd1;
    localparam logic [2:0] OP_LH = 3'd2;
    localparam logic [2:0] OP_LB = 3'd3;
    localparam logic [2:0] OP_SW = 3'd4;
    localparam logic [2:0] OP_SH = 3'd5;
    localparam logic [2:0] OP_SB = 3'd6;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [1:0]  lo_q, lo_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic        is_load, is_store, misaligned, accept;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [15:0] load_half;
    logic [7:0]  load_byte;
    logic [31:0] load_ext;
    logic        stall_raw;
    logic        timeout;

    // Decode the incoming op: class, alignment, and lane placement for stores
    always_comb begin
        is_load    = 1'b0;
        is_store   = 1'b0;
        misaligned = 1'b0;
        be_new     = 4'b1111;
        wdata_new  = mif.wdata;
        case (mif.MemOp)
            OP_LW: begin
                is_load    = 1'b1;
                misaligned = |mif.addr[1:0];
            end
            OP_LH: begin
                is_load    = 1'b1;
                misaligned = mif.addr[0];
            end
            OP_LB: is_load = 1'b1;
            OP_SW: begin
                is_store   = 1'b1;
                misaligned = |mif.addr[1:0];
            end
            OP_SH: begin
                is_store   = 1'b1;
                misaligned = mif.addr[0];
                be_new     = mif.addr[1] ? 4'b1100 : 4'b0011;
                wdata_new  = {2{mif.wdata[15:0]}};
            end
            OP_SB: begin
                is_store   = 1'b1;
                be_new     = 4'b0001 << mif.addr[1:0];
                wdata_new  = {4{mif.wdata[7:0]}};
            end
            default: ;  // NONE and the unused encoding 7
        endcase
    end

    // Only the IDLE decision cycle looks at the M-stage inputs
    assign accept = (state_q == S_IDLE) && mif.m_valid && (is_load || is_store) && !misaligned;

    // Select and sign-extend the returned lane using the latched op/offset
    always_comb begin
        load_half = lo_q[1] ? mif.bus_rdata[31:16] : mif.bus_rdata[15:0];
        case (lo_q)
            2'd0:    load_byte = mif.bus_rdata[7:0];
            2'd1:    load_byte = mif.bus_rdata[15:8];
            2'd2:    load_byte = mif.bus_rdata[23:16];
            default: load_byte = mif.bus_rdata[31:24];
        endcase
        case (op_q)
            OP_LH:   load_ext = {{16{load_half[15]}}, load_half};
            OP_LB:   load_ext = {{24{load_byte[7]}}, load_byte};
            default: load_ext = mif.bus_rdata;
        endcase
    end

    // Next-state and stall decision
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        lo_d        = lo_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
        stall_raw   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    stall_raw   = 1'b1;
                    state_d     = S_REQ;
                    op_d        = mif.MemOp;
                    lo_d        = mif.addr[1:0];
                    bus_we_d    = is_store;
                    bus_addr_d  = {mif.addr[31:2], 2'b00};
                    bus_be_d    = be_new;
                    bus_wdata_d = wdata_new;
                end
            end
            S_REQ: begin
                stall_raw = 1'b1;
                // A granted store has completed, so it wins over a coincident timeout
                if (mif.bus_gnt && bus_we_q) begin
                    state_d = S_DONE;
                end else if (timeout) begin
                    state_d = S_DONE;
                end else if (mif.bus_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                stall_raw = 1'b1;
                if (mif.bus_rvalid) begin
                    rdata_d = load_ext;
                    state_d = S_DONE;
                end else if (timeout) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and latched access registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= 3'd0;
            lo_q        <= 2'd0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_be_q    <= 4'd0;
            bus_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            lo_q        <= lo_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

`ifdef MEMCTL_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             busy;

    assign busy = (state_q == S_REQ) || (state_q == S_WAIT);
    // The cycle holding CNT_LAST is the last one allowed; the count reaches
    // TIMEOUT_CYCLES on the edge into DONE
    assign timeout = busy && (cnt_q == CNT_LAST);

    // Cycle counter: cleared on entry to REQ, counts while the access is on the bus
    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = '0;
        end else if (busy) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        err_d = timeout
              && !((state_q == S_REQ)  && mif.bus_gnt && bus_we_q)
              && !((state_q == S_WAIT) && mif.bus_rvalid);
    end

    // Counter and abort flag; err_q is high exactly in the DONE cycle of an abort
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign mif.bus_err = err_q;
`else
    // Parameter only matters for the timeout build
    logic param_unused;
    assign param_unused = ^TIMEOUT_CYCLES;
    assign timeout      = 1'b0;
    assign mif.bus_err  = 1'b0;
`endif

    assign mif.stall     = stall_raw && !reset;
    assign mif.exc_adel  = (state_q == S_IDLE) && mif.m_valid && is_load  && misaligned;
    assign mif.exc_ades  = (state_q == S_IDLE) && mif.m_valid && is_store && misaligned;
    assign mif.bus_req   = (state_q == S_REQ);
    assign mif.done      = (state_q == S_DONE);
    assign mif.bus_we    = bus_we_q;
    assign mif.bus_addr  = bus_addr_q;
    assign mif.bus_be    = bus_be_q;
    assign mif.bus_wdata = bus_wdata_q;
    assign mif.rdata     = rdata_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: per-access scoreboard of the
// expected completion plus inline checks of bus fields and exceptions.
module tb_mem_access_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_access_ctrl_if mif();

`ifdef MEMCTL_TIMEOUT_EN
    localparam int TB_TO = 8;
    mem_access_ctrl #(.TIMEOUT_CYCLES(TB_TO)) dut (.clk(clk), .reset(reset), .mif(mif));
`else
    localparam int TB_TO = 255;
    mem_access_ctrl dut (.clk(clk), .reset(reset), .mif(mif));
`endif

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic [31:0] baddr;
        logic [3:0]  be;
        logic [31:0] bwdata;
        logic        we;
        logic        err;
        int          stalls;
        int          reqs;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_rd  = 32'd0;

    function automatic logic [3:0] exp_be(input logic [2:0] op, input logic [31:0] a);
        logic [3:0] one;
        one = 4'b0001;
        case (op)
            3'd5:    return a[1] ? 4'b1100 : 4'b0011;
            3'd6:    return one << a[1:0];
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] exp_bwdata(input logic [2:0] op, input logic [31:0] wd);
        case (op)
            3'd5:    return {wd[15:0], wd[15:0]};
            3'd6:    return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] exp_ext(input logic [2:0] op, input logic [31:0] a, input logic [31:0] w);
        logic [15:0] h;
        logic [7:0]  b;
        h = a[1] ? w[31:16] : w[15:0];
        b = w[8*a[1:0] +: 8];
        case (op)
            3'd2:    return {{16{h[15]}}, h};
            3'd3:    return {{24{b[7]}}, b};
            default: return w;
        endcase
    endfunction

    // Drive one access starting at a negedge; returns at the negedge after done.
    task automatic run_access(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input int gdly, input int rdly,
                              input bit to_err, input string name);
        exp_t e, got;
        int   stalls = 0;
        int   reqs   = 0;
        int   gcyc   = -1;
        bit   fin    = 0;
        bit   ld;
        ld       = (op >= 3'd1) && (op <= 3'd3);
        e.name   = name;
        e.baddr  = {a[31:2], 2'b00};
        e.be     = exp_be(op, a);
        e.bwdata = exp_bwdata(op, wd);
        e.we     = !ld;
        e.err    = to_err;
        e.rdata  = (ld && !to_err) ? exp_ext(op, a, rd) : last_rd;
        e.stalls = to_err ? 1 + TB_TO : 2 + gdly + (ld ? rdly : 0);
        e.reqs   = gdly + 1;
        last_rd  = e.rdata;
        sb.push_back(e);

        mif.m_valid = 1'b1;
        mif.MemOp   = op;
        mif.addr    = a;
        mif.wdata   = wd;
        for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
            mif.bus_gnt    = mif.bus_req && (reqs == gdly);
            mif.bus_rvalid = (gcyc >= 0) && (cyc - gcyc == rdly);
            mif.bus_rdata  = mif.bus_rvalid ? rd : 32'h5A5A_5A5A;
            #1;
            if (mif.stall) stalls++;
            if (mif.bus_req) begin
                reqs++;
                n_checks++;
                if ({mif.bus_addr, mif.bus_be, mif.bus_wdata, mif.bus_we} !== {e.baddr, e.be, e.bwdata, e.we}) begin
                    n_fail++;
                    $display("FAIL %s bus fields: got addr=%h be=%b wdata=%h we=%b, want addr=%h be=%b wdata=%h we=%b",
                             name, mif.bus_addr, mif.bus_be, mif.bus_wdata, mif.bus_we,
                             e.baddr, e.be, e.bwdata, e.we);
                end
            end
            if (mif.bus_gnt) gcyc = cyc;
            if (mif.done) begin
                fin = 1;
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s done: got unexpected done pulse, want none", name);
                end else begin
                    got = sb.pop_front();
                    if (mif.rdata !== got.rdata) begin
                        n_fail++;
                        $display("FAIL %s rdata: got %h want %h", name, mif.rdata, got.rdata);
                    end
                    n_checks++;
                    if (mif.bus_err !== got.err) begin
                        n_fail++;
                        $display("FAIL %s bus_err: got %b want %b", name, mif.bus_err, got.err);
                    end
                    n_checks++;
                    if (stalls != got.stalls) begin
                        n_fail++;
                        $display("FAIL %s stall cycles: got %0d want %0d", name, stalls, got.stalls);
                    end
                    n_checks++;
                    if (reqs != got.reqs) begin
                        n_fail++;
                        $display("FAIL %s bus_req cycles: got %0d want %0d", name, reqs, got.reqs);
                    end
                end
            end else if (mif.bus_err !== 1'b0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s bus_err outside done: got %b want 0", name, mif.bus_err);
            end
            @(negedge clk);
        end
        mif.bus_gnt    = 1'b0;
        mif.bus_rvalid = 1'b0;
        n_checks++;
        if (!fin) begin
            n_fail++;
            $display("FAIL %s completion: got no done within 60 cycles, want done", name);
            if (sb.size() != 0) void'(sb.pop_back());
        end
        $display("access %s op=%0d addr=%h rdata=%h stalls=%0d reqs=%0d", name, op, a, mif.rdata, stalls, reqs);
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        mif.m_valid    = 1'b0;
        mif.MemOp      = 3'd0;
        mif.addr       = 32'd0;
        mif.wdata      = 32'd0;
        mif.bus_gnt    = 1'b0;
        mif.bus_rvalid = 1'b0;
        mif.bus_rdata  = 32'd0;
        repeat (2) @(negedge clk);
        mif.m_valid = 1'b1;
        mif.MemOp   = 3'd1;
        #1;
        n_checks++;
        if ({mif.stall, mif.done, mif.bus_req, mif.bus_we, mif.bus_err} !== 5'b0
            || mif.bus_addr !== 32'd0 || mif.bus_be !== 4'd0 || mif.bus_wdata !== 32'd0 || mif.rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset outputs: got stall=%b done=%b req=%b we=%b err=%b addr=%h be=%b wd=%h rdata=%h, want all 0",
                     mif.stall, mif.done, mif.bus_req, mif.bus_we, mif.bus_err,
                     mif.bus_addr, mif.bus_be, mif.bus_wdata, mif.rdata);
        end
        mif.m_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        $display("reset released");
    endtask

    task automatic test_lw();
        run_access(3'd1, 32'h0000_1000, 32'd0, 32'hDEAD_BEEF, 0, 2, 0, "lw_1000");
    endtask

    task automatic test_loads();
        run_access(3'd3, 32'h0000_2003, 32'd0, 32'h80FF_FFFF, 0, 1, 0, "lb_2003");
        run_access(3'd2, 32'h0000_2002, 32'd0, 32'h7FFF_0000, 1, 1, 0, "lh_2002");
        run_access(3'd2, 32'h0000_2000, 32'd0, 32'h1234_8001, 0, 1, 0, "lh_2000");
        run_access(3'd3, 32'h0000_2001, 32'd0, 32'h0000_7F00, 2, 3, 0, "lb_2001");
    endtask

    task automatic test_stores();
        run_access(3'd6, 32'h0000_3001, 32'h0000_00AB, 32'd0, 3, 1, 0, "sb_3001");
        run_access(3'd5, 32'h0000_3002, 32'h1234_BEEF, 32'd0, 0, 1, 0, "sh_3002");
        run_access(3'd4, 32'h0000_3000, 32'hCAFE_F00D, 32'd0, 1, 1, 0, "sw_3000");
    endtask

    task automatic test_back_to_back();
        logic [2:0]  op;
        logic [31:0] a;
        for (int i = 0; i < 6; i++) begin
            op = 3'($urandom_range(1, 6));
            a  = $urandom;
            if (op == 3'd1 || op == 3'd4) a[1:0] = 2'b00;
            if (op == 3'd2 || op == 3'd5) a[0]   = 1'b0;
            run_access(op, a, $urandom, $urandom, $urandom_range(0, 2), $urandom_range(1, 3), 0, "b2b");
        end
    endtask

    task automatic test_misaligned();
        mif.m_valid = 1'b1;
        mif.MemOp   = 3'd1;
        mif.addr    = 32'h0000_1002;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++;
            if ({mif.exc_adel, mif.exc_ades, mif.stall, mif.bus_req} !== 4'b1000) begin
                n_fail++;
                $display("FAIL misaligned lw: got adel=%b ades=%b stall=%b req=%b, want 1 0 0 0",
                         mif.exc_adel, mif.exc_ades, mif.stall, mif.bus_req);
            end
            @(negedge clk);
        end
        $display("misaligned lw addr=%h adel=%b", mif.addr, mif.exc_adel);
        mif.MemOp = 3'd5;
        mif.addr  = 32'h0000_1001;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++;
            if ({mif.exc_adel, mif.exc_ades, mif.stall, mif.bus_req} !== 4'b0100) begin
                n_fail++;
                $display("FAIL misaligned sh: got adel=%b ades=%b stall=%b req=%b, want 0 1 0 0",
                         mif.exc_adel, mif.exc_ades, mif.stall, mif.bus_req);
            end
            @(negedge clk);
        end
        $display("misaligned sh addr=%h ades=%b", mif.addr, mif.exc_ades);
        mif.m_valid = 1'b0;
        #1;
        n_checks++;
        if ({mif.exc_adel, mif.exc_ades} !== 2'b00) begin
            n_fail++;
            $display("FAIL misaligned invalid: got adel=%b ades=%b, want 0 0", mif.exc_adel, mif.exc_ades);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        mif.m_valid = 1'b1;
        mif.MemOp   = 3'd1;
        mif.addr    = 32'h0000_4000;
        @(negedge clk);                 // REQ
        mif.bus_gnt = 1'b1;
        @(negedge clk);                 // WAIT
        mif.bus_gnt = 1'b0;
        mif.m_valid = 1'b0;
        #1;
        n_checks++;
        if ({mif.stall, mif.bus_req} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_mid in wait: got stall=%b req=%b, want 1 0", mif.stall, mif.bus_req);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({mif.stall, mif.bus_req, mif.done} !== 3'b000 || mif.rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid async: got stall=%b req=%b done=%b rdata=%h, want 0 0 0 0",
                     mif.stall, mif.bus_req, mif.done, mif.rdata);
        end
        last_rd = 32'd0;
        @(negedge clk);
        reset          = 1'b0;
        mif.bus_rvalid = 1'b1;
        mif.bus_rdata  = 32'h1234_5678;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_checks++;
            if ({mif.done, mif.bus_req, mif.stall} !== 3'b000 || mif.rdata !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_mid after: got done=%b req=%b stall=%b rdata=%h, want 0 0 0 0",
                         mif.done, mif.bus_req, mif.stall, mif.rdata);
            end
            @(negedge clk);
            mif.bus_rvalid = 1'b0;
        end
        $display("reset mid-access: rdata=%h", mif.rdata);
        run_access(3'd1, 32'h0000_6004, 32'd0, 32'h0BAD_F00D, 1, 1, 0, "lw_after_reset");
    endtask

`ifdef MEMCTL_TIMEOUT_EN
    task automatic test_timeout();
        run_access(3'd1, 32'h0000_5000, 32'd0, 32'd0, 0, 1000, 1, "timeout");
        run_access(3'd3, 32'h0000_5003, 32'd0, 32'h0000_0000, 0, 1, 0, "lb_after_timeout");
    endtask
`endif

    initial begin
        test_reset();
        test_lw();
        test_loads();
        test_stores();
        test_back_to_back();
        test_misaligned();
        test_reset_mid();
`ifdef MEMCTL_TIMEOUT_EN
        test_timeout();
`endif
        mif.m_valid = 1'b0;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard: got %0d pending entries, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
